// File: rtl/layer_weight_bias_fetch.sv
// Per-layer read requester: sequences one weight-then-bias fetch through the shared
// arbiter and returns each word tagged with its index in the fetch.
module layer_weight_bias_fetch #(
    parameter logic [4:0]  LAYER_ID    = 5'd1,
    parameter logic [15:0] WEIGHT_BASE = 16'd0,
    parameter logic [15:0] WEIGHT_NUM  = 16'd72,
    parameter logic [15:0] BIAS_BASE   = 16'd0,
    parameter logic [15:0] BIAS_NUM    = 16'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  weight_sel,
    input  logic [4:0]  bias_sel,
    output logic        read_weight_signal,
    output logic [15:0] read_weight_addr,
    output logic        read_bias_signal,
    output logic [15:0] read_bias_addr,
    input  logic [15:0] read_weight_data,
    input  logic [15:0] read_bias_data,
    output logic        weight_valid,
    output logic [15:0] weight_out,
    output logic [15:0] weight_index,
    output logic        bias_valid,
    output logic [15:0] bias_out,
    output logic [15:0] bias_index,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, W_FETCH, B_FETCH, DRAIN, DONE} state_t;

    state_t      state, next_state;
    logic [15:0] wcnt, bcnt, wcnt_next, bcnt_next;
    logic        w_grant, b_grant, w_last, b_last;
    logic        w_pend, b_pend;
    logic [15:0] w_pend_idx, b_pend_idx;
    logic        w_sig_d, b_sig_d;
    logic [15:0] w_addr_d, b_addr_d;

    assign w_grant = (state == W_FETCH) && (weight_sel == LAYER_ID);
    assign b_grant = (state == B_FETCH) && (bias_sel == LAYER_ID);
    assign w_last  = (wcnt == WEIGHT_NUM - 16'd1);
    assign b_last  = (bcnt == BIAS_NUM - 16'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) begin
                if (WEIGHT_NUM != 16'd0)    next_state = W_FETCH;
                else if (BIAS_NUM != 16'd0) next_state = B_FETCH;
                else                        next_state = DRAIN;
            end
            W_FETCH: if (w_grant && w_last)
                next_state = (BIAS_NUM != 16'd0) ? B_FETCH : DRAIN;
            B_FETCH: if (b_grant && b_last) next_state = DRAIN;
            DRAIN:   if (!w_pend && !b_pend) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request outputs are registered, so they are computed from the state being entered.
    always_comb begin
        wcnt_next = wcnt;
        bcnt_next = bcnt;
        if (state == IDLE && start) begin
            wcnt_next = 16'd0;
            bcnt_next = 16'd0;
        end else begin
            if (w_grant && !w_last) wcnt_next = wcnt + 16'd1;
            if (b_grant && !b_last) bcnt_next = bcnt + 16'd1;
        end
        w_sig_d  = (next_state == W_FETCH);
        b_sig_d  = (next_state == B_FETCH);
        w_addr_d = w_sig_d ? WEIGHT_BASE + wcnt_next : 16'd0;
        b_addr_d = b_sig_d ? BIAS_BASE + bcnt_next : 16'd0;
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt               <= 16'd0;
            bcnt               <= 16'd0;
            read_weight_signal <= 1'b0;
            read_weight_addr   <= 16'd0;
            read_bias_signal   <= 1'b0;
            read_bias_addr     <= 16'd0;
        end else begin
            wcnt               <= wcnt_next;
            bcnt               <= bcnt_next;
            read_weight_signal <= w_sig_d;
            read_weight_addr   <= w_addr_d;
            read_bias_signal   <= b_sig_d;
            read_bias_addr     <= b_addr_d;
        end
    end

    // Two-stage return pipes: remember the granted index, then capture the memory word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_pend       <= 1'b0;
            w_pend_idx   <= 16'd0;
            b_pend       <= 1'b0;
            b_pend_idx   <= 16'd0;
            weight_valid <= 1'b0;
            weight_out   <= 16'd0;
            weight_index <= 16'd0;
            bias_valid   <= 1'b0;
            bias_out     <= 16'd0;
            bias_index   <= 16'd0;
        end else begin
            w_pend       <= w_grant;
            w_pend_idx   <= wcnt;
            b_pend       <= b_grant;
            b_pend_idx   <= bcnt;
            weight_valid <= w_pend;
            bias_valid   <= b_pend;
            if (w_pend) begin
                weight_out   <= read_weight_data;
                weight_index <= w_pend_idx;
            end
            if (b_pend) begin
                bias_out   <= read_bias_data;
                bias_index <= b_pend_idx;
            end
        end
    end

endmodule
